// File: rtl/pipelined_ripple_adder_if.sv
// pipelined_ripple_adder_if: operand/result valid-ready bus; carries sub when PRA_SUB_EN is defined
interface pipelined_ripple_adder_if #(
  parameter int WIDTH = 32
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic cin;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] sum;
  logic cout;
`ifdef PRA_SUB_EN
  logic sub;
`endif
  modport master (
`ifdef PRA_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input in_ready, out_valid, sum, cout
  );
  modport slave (
`ifdef PRA_SUB_EN
    input sub,
`endif
    input in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: WIDTH-bit adder as SLICE-bit ripple stages, one register per slice; PRA_SUB_EN adds A-B mode
module pipelined_ripple_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic clk,
  input logic rst,
  pipelined_ripple_adder_if.slave bus
);
  localparam int STAGES = WIDTH / SLICE;
  logic adv;
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SLICE;
    localparam int RW = WIDTH - LO;
    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] xn;
    logic [WIDTH-1:0] x;
    logic [RW-1:0] bi;
    logic [SLICE-1:0] bs;
    logic ci;
    logic vi;
    logic cn;
    logic c;
    logic v;
`ifdef PRA_SUB_EN
    logic si;
    assign bs = bi[SLICE-1:0] ^ {SLICE{si}};
`else
    assign bs = bi[SLICE-1:0];
`endif
    if (k == 0) begin : g_in
      assign ai = bus.a;
      assign bi = bus.b;
      assign vi = bus.in_valid;
`ifdef PRA_SUB_EN
      assign si = bus.sub;
      assign ci = bus.sub || bus.cin;
`else
      assign ci = bus.cin;
`endif
    end else begin : g_in
      assign ai = g_st[k-1].x;
      assign bi = g_st[k-1].g_up.bu;
      assign ci = g_st[k-1].c;
      assign vi = g_st[k-1].v;
`ifdef PRA_SUB_EN
      assign si = g_st[k-1].g_up.su;
`endif
    end
    // x keeps finished sum bits below the slice and untouched A bits above it
    always_comb begin
      cn = ci;
      xn = ai;
      for (int i = 0; i < SLICE; i++) begin
        xn[LO+i] = ai[LO+i] ^ bs[i] ^ cn;
        cn = (ai[LO+i] & bs[i]) | (cn & (ai[LO+i] ^ bs[i]));
      end
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v <= 1'b0;
        c <= 1'b0;
        x <= '0;
      end else if (adv) begin
        v <= vi;
        c <= cn;
        x <= xn;
      end
    end
    if (k < STAGES - 1) begin : g_up
      logic [RW-SLICE-1:0] bu;
`ifdef PRA_SUB_EN
      logic su;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) su <= 1'b0;
        else if (adv) su <= si;
      end
`endif
      always_ff @(posedge clk or posedge rst) begin
        if (rst) bu <= '0;
        else if (adv) bu <= bi[RW-1:SLICE];
      end
    end
  end
  assign bus.out_valid = g_st[STAGES-1].v;
  assign bus.sum = g_st[STAGES-1].x;
  assign bus.cout = g_st[STAGES-1].c;
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb_pipelined_ripple_adder: scoreboard bench for 32/8, 16/16 and 24/4 builds sharing one stimulus stream
module tb_pipelined_ripple_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pipelined_ripple_adder_if #(.WIDTH(32)) m();
  pipelined_ripple_adder_if #(.WIDTH(16)) p();
  pipelined_ripple_adder_if #(.WIDTH(24)) q();
  pipelined_ripple_adder #(.WIDTH(32), .SLICE(8)) u0 (.clk(clk), .rst(rst), .bus(m));
  pipelined_ripple_adder #(.WIDTH(16), .SLICE(16)) u1 (.clk(clk), .rst(rst), .bus(p));
  pipelined_ripple_adder #(.WIDTH(24), .SLICE(4)) u2 (.clk(clk), .rst(rst), .bus(q));
`ifdef PRA_SUB_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_out0 = 0;
  int n_out1 = 0;
  int n_out2 = 0;
  logic [63:0] exp0[$];
  logic [63:0] exp1[$];
  logic [63:0] exp2[$];
  int pop_cyc[$];
  logic st0 = 1'b0;
  logic [63:0] hold0 = '0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endfunction
  function automatic void miss(input string nm, input logic [63:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %0h with nothing expected", nm, act);
  endfunction
  // reference: plain arithmetic on WIDTH+1 bits, subtraction as A + ~B + 1
  function automatic logic [63:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic c, input logic s);
    logic [63:0] mask;
    logic [63:0] bb;
    mask = (64'd1 << w) - 64'd1;
    bb = s ? (~b & mask) : (b & mask);
    return (a & mask) + bb + 64'(s | c);
  endfunction
  always @(negedge clk) begin
    #2;
    if (rst) begin
      st0 = 1'b0;
    end else begin
      if (st0) begin
        chk("stall_valid", 64'(m.out_valid), 64'd1);
        chk("stall_hold", {m.cout, m.sum}, hold0);
      end
      if (m.out_valid && m.out_ready) begin
        if (exp0.size() == 0) miss("out32 extra beat", {m.cout, m.sum});
        else chk("out32", {m.cout, m.sum}, exp0.pop_front());
        pop_cyc.push_back(cyc);
        n_out0++;
      end
      st0 = m.out_valid && !m.out_ready;
      hold0 = {m.cout, m.sum};
      if (p.out_valid && p.out_ready) begin
        if (exp1.size() == 0) miss("out16 extra beat", {p.cout, p.sum});
        else chk("out16", {p.cout, p.sum}, exp1.pop_front());
        n_out1++;
      end
      if (q.out_valid && q.out_ready) begin
        if (exp2.size() == 0) miss("out24 extra beat", {q.cout, q.sum});
        else chk("out24", {q.cout, q.sum}, exp2.pop_front());
        n_out2++;
      end
    end
  end
  // called at a negedge; returns at the next negedge
  task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic s, input logic ordy, output logic acc);
    m.in_valid = iv; m.a = a; m.b = b; m.cin = c; m.out_ready = ordy;
    p.in_valid = iv; p.a = a[15:0]; p.b = b[15:0]; p.cin = c;
    q.in_valid = iv; q.a = a[23:0]; q.b = b[23:0]; q.cin = c;
`ifdef PRA_SUB_EN
    m.sub = s; p.sub = s; q.sub = s;
`endif
    #1;
    acc = iv && m.in_ready;
    if (acc) exp0.push_back(model(32, 64'(a), 64'(b), c, s & SUB));
    if (iv && p.in_ready) exp1.push_back(model(16, 64'(a), 64'(b), c, s & SUB));
    if (iv && q.in_ready) exp2.push_back(model(24, 64'(a), 64'(b), c, s & SUB));
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end
  initial begin
    logic acc;
    logic pend;
    logic iv;
    logic [31:0] ra;
    logic [31:0] rb;
    logic rc;
    logic rs;
    int lat0;
    int lat1;
    int lat2;
    int base;
    int b1;
    int b2;
    logic [31:0] corner [4];
    corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'hAAAA_AAAA; corner[3] = 32'h5555_5555;
    m.in_valid = 0; m.a = 0; m.b = 0; m.cin = 0; m.out_ready = 1;
    p.in_valid = 0; p.a = 0; p.b = 0; p.cin = 0; p.out_ready = 1;
    q.in_valid = 0; q.a = 0; q.b = 0; q.cin = 0; q.out_ready = 1;
`ifdef PRA_SUB_EN
    m.sub = 0; p.sub = 0; q.sub = 0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(m.out_valid), 64'd0);
    chk("rst_sum", 64'(m.sum), 64'd0);
    chk("rst_cout", 64'(m.cout), 64'd0);
    chk("rst_in_ready", 64'(m.in_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(m.in_ready), 64'd1);
    // one beat whose carry must ripple through every stage
    step(1, 32'hFFFF_FFFF, 32'h1, 0, 0, 1, acc);
    lat0 = -1; lat1 = -1; lat2 = -1;
    for (int i = 1; i <= 10; i++) begin
      if (lat0 < 0 && m.out_valid) begin lat0 = i; chk("ripple32", {m.cout, m.sum}, 64'h1_0000_0000); end
      if (lat1 < 0 && p.out_valid) begin lat1 = i; chk("ripple16", {p.cout, p.sum}, 64'h1_0000); end
      if (lat2 < 0 && q.out_valid) begin lat2 = i; chk("ripple24", {q.cout, q.sum}, 64'h100_0000); end
      step(0, 0, 0, 0, 0, 1, acc);
    end
    chk("latency32", 64'(lat0), 64'd4);
    chk("latency16", 64'(lat1), 64'd1);
    chk("latency24", 64'(lat2), 64'd6);
    step(1, 32'h8000, 32'h8000, 1, 0, 1, acc);
    chk("w16_valid", 64'(p.out_valid), 64'd1);
    chk("w16_8000", {p.cout, p.sum}, 64'h1_0001);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int c = 0; c < 2; c++) step(1, corner[i], corner[j], c[0], 0, 1, acc);
`ifdef PRA_SUB_EN
    step(1, 32'd5, 32'd7, 0, 1, 1, acc);
    step(1, 32'd7, 32'd5, 0, 1, 1, acc);
`endif
    repeat (8) step(0, 0, 0, 0, 0, 1, acc);
    base = n_out0;
    for (int i = 0; i < 100; i++) begin
      step(1, $urandom, $urandom, 1'($urandom % 2), 1'($urandom % 2), 1, acc);
      chk("stream_in_ready", 64'(acc), 64'd1);
    end
    repeat (6) step(0, 0, 0, 0, 0, 1, acc);
    chk("stream_count", 64'(n_out0 - base), 64'd100);
    if (pop_cyc.size() >= base + 100) chk("stream_rate", 64'(pop_cyc[base+99] - pop_cyc[base]), 64'd99);
    pend = 0; iv = 0; ra = 0; rb = 0; rc = 0; rs = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        iv = 1'($urandom % 2); ra = $urandom; rb = $urandom; rc = 1'($urandom % 2); rs = 1'($urandom % 2);
      end
      step(iv, ra, rb, rc, rs, 1'($urandom % 2), acc);
      pend = iv && !acc;
    end
    for (int i = 0; i < 50 && (exp0.size() + exp2.size()) > 0; i++) step(0, 0, 0, 0, 0, 1, acc);
    chk("drain32", 64'(exp0.size()), 64'd0);
    chk("drain16", 64'(exp1.size()), 64'd0);
    chk("drain24", 64'(exp2.size()), 64'd0);
    // three beats in flight, first one parked at the output, then reset
    step(1, 32'h1234, 32'h1, 0, 0, 1, acc);
    step(1, 32'h5678, 32'h2, 1, 0, 1, acc);
    step(1, 32'h9ABC, 32'h3, 0, 0, 1, acc);
    step(0, 0, 0, 0, 0, 0, acc);
    chk("pre_rst_valid", 64'(m.out_valid), 64'd1);
    m.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(m.out_valid), 64'd0);
    chk("async_rst_sum", 64'(m.sum), 64'd0);
    chk("async_rst_cout", 64'(m.cout), 64'd0);
    exp0.delete(); exp1.delete(); exp2.delete();
    base = n_out0; b1 = n_out1; b2 = n_out2;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) step(0, 0, 0, 0, 0, 1, acc);
    chk("flush32", 64'(n_out0 - base), 64'd0);
    chk("flush16", 64'(n_out1 - b1), 64'd0);
    chk("flush24", 64'(n_out2 - b2), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipelined_ripple_adder.md
# pipelined_ripple_adder

Parametrised, pipelined successor to the team's fixed 32-bit ripple adder. Splits a WIDTH-bit addition into SLICE-bit ripple slices with one register stage per slice, so the carry chain per cycle is only SLICE bits long. Carries a valid/ready handshake on both sides with full backpressure, and sits between operand sources and ALU/accumulator consumers that need high clock rates.

## Interface
- WIDTH, default 32: operand and sum width. Must be a multiple of SLICE.
- SLICE, default 8: bits added per pipeline stage. STAGES = WIDTH/SLICE.
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  adder accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  A + B + cin, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.

## Operation
- Stage k (0..STAGES-1) adds slice k of A and B plus the carry registered by stage k-1. Stage 0 uses cin. Each slice is an ordinary full-adder ripple.
- Each stage register holds:
  - a valid bit;
  - the completed low sum bits;
  - the carry;
  - the not-yet-added upper operand bits, passed forward unchanged (skew buffering).
- Global advance: `adv = !out_valid | out_ready`. When adv=1, every stage loads from its predecessor, stage 0 loads the input beat, and valid bits shift. When adv=0, all registers hold.
- `in_ready = adv` (combinational from out_ready and out_valid). A beat transfers when `in_valid & in_ready`. If in_valid=0 while advancing, a bubble (valid=0) enters.
- out_valid, sum and cout come directly from the final stage register. No combinational path from a/b to sum.
- Bubbles are not collapsed. A beat emerges exactly STAGES advancing cycles after acceptance.
- Results are in acceptance order. No beat is dropped or duplicated under any out_ready pattern.

## Timing
- Reset values: out_valid=0, sum=0, cout=0, all stage valids=0. in_ready=1 during and after reset (out_valid=0).
- Reset is asynchronous at assertion: pipeline contents are discarded immediately, including mid-flight beats. Deassertion is synchronised externally.
- Latency: beat accepted at edge n is presented with out_valid=1 after edge n+STAGES, provided out_ready was not low on any intervening cycle where out_valid=1.
- Throughput: one beat per cycle with out_ready held high.
- Stall:
  - out_valid=1 and out_ready=0 freezes the whole pipeline; sum and cout stay stable.
  - in_ready=0 in the same cycle; an offered input must be held by the source.
- Simultaneous out handshake and in handshake in one cycle is legal and required for full rate.
- STAGES=1 (SLICE=WIDTH): a single registered adder with latency 1.

## Configuration
- PRA_SUB_EN defined:
  - adds input port `sub` (1 bit), sampled with the operands and carried down the pipeline.
  - sub=1: the adder computes A + ~B + 1 (A − B); cin is ignored and cout=1 means no borrow.
  - sub=0: identical to the plain adder.
- PRA_SUB_EN undefined: no `sub` port, add-only behaviour, no extra registers.

## Test plan
- Reset then single beat, WIDTH=32 SLICE=8: a=0xFFFFFFFF, b=0x00000001, cin=0 -> after 4 cycles out_valid=1, sum=0x00000000, cout=1. Carry must ripple through all stages.
- Streaming: 100 back-to-back random beats with out_ready=1 -> in_ready constantly 1; results in order and equal to the reference sum; first result at cycle 4 and one per cycle after.
- Backpressure: random out_ready (50%) and random in_valid -> no loss, duplication or reordering; sum and cout stable while out_valid=1 and out_ready=0.
- Mid-flight reset: accept 3 beats, assert rst for 1 cycle -> out_valid=0, sum=0, cout=0 immediately; none of the 3 beats ever appears.
- Parameter sweep WIDTH=16 SLICE=16 and WIDTH=24 SLICE=4: a=0x8000, b=0x8000, cin=1 (16-bit) -> latency 1, sum=0x0001, cout=1; 24/4 latency 6, exhaustive corner operands (0, all-ones, alternating) match.
- PRA_SUB_EN: a=5, b=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0. a=7, b=5, sub=1 -> sum=2, cout=1.
